// File: rtl/fifo_stream_checker.sv
// fifo_stream_checker: read-side sink for the dual-clock FIFO.
// Drains data_out with a programmable ack throttle, checks the words against
// the producer's incrementing pattern (1, 2, ..., skip 0 on wrap), counts
// transfers and mismatches, and raises done after num_words transfers.
// Optional: define FIRST_ERR_CAPTURE_EN to add err_index / err_expected /
// err_actual, which record the first mismatching transfer after each start.
module fifo_stream_checker #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned ACK_GAP    = 0
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [CNT_WIDTH-1:0]  num_words,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  data_out_valid,
    output logic                  data_out_ack,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic                  error,
    output logic                  done,
    output logic                  busy
`ifdef FIRST_ERR_CAPTURE_EN
    ,
    output logic [CNT_WIDTH-1:0]  err_index,
    output logic [DATA_WIDTH-1:0] err_expected,
    output logic [DATA_WIDTH-1:0] err_actual
`endif
);

    localparam int unsigned GAP_W = (ACK_GAP > 0) ? $clog2(ACK_GAP + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_GAP,
        S_DONE
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] expected;
    logic [GAP_W-1:0]      gap_cnt;

    logic                  xfer;
    logic                  mismatch;
    logic                  hit_target;
    logic [CNT_WIDTH-1:0]  wc_inc;
    logic [DATA_WIDTH-1:0] succ;

    // Transfer detection, pattern compare and next-expected computation.
    always_comb begin
        xfer       = data_out_valid & data_out_ack;
        mismatch   = (data_out != expected);
        wc_inc     = word_count + CNT_WIDTH'(1);
        hit_target = (num_words != '0) && (wc_inc == num_words);
        succ       = data_out + DATA_WIDTH'(1);
        if (succ == '0) begin
            succ = DATA_WIDTH'(1);
        end
    end

    // Control FSM with registered ack/done/busy plus counters and checker state.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            data_out_ack <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
            word_count   <= '0;
            err_count    <= '0;
            expected     <= DATA_WIDTH'(1);
            gap_cnt      <= '0;
`ifdef FIRST_ERR_CAPTURE_EN
            err_index    <= '0;
            err_expected <= '0;
            err_actual   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    data_out_ack <= 1'b0;
                    done         <= 1'b0;
                    busy         <= 1'b0;
                    if (enable) begin
                        state        <= S_ACK;
                        data_out_ack <= 1'b1;
                        busy         <= 1'b1;
                        word_count   <= '0;
                        err_count    <= '0;
                        error        <= 1'b0;
                        expected     <= DATA_WIDTH'(1);
`ifdef FIRST_ERR_CAPTURE_EN
                        err_index    <= '0;
                        err_expected <= '0;
                        err_actual   <= '0;
`endif
                    end
                end

                S_ACK: begin
                    if (xfer) begin
                        word_count <= wc_inc;
                        expected   <= succ;
                        if (mismatch) begin
                            error <= 1'b1;
                            if (err_count != '1) begin
                                err_count <= err_count + CNT_WIDTH'(1);
                            end
`ifdef FIRST_ERR_CAPTURE_EN
                            // error is cleared on start, so !error marks the first mismatch
                            if (!error) begin
                                err_index    <= word_count;
                                err_expected <= expected;
                                err_actual   <= data_out;
                            end
`endif
                        end
                        if (!enable) begin
                            state        <= S_IDLE;
                            data_out_ack <= 1'b0;
                            busy         <= 1'b0;
                        end else if (hit_target) begin
                            state        <= S_DONE;
                            data_out_ack <= 1'b0;
                            busy         <= 1'b0;
                            done         <= 1'b1;
                        end else if (ACK_GAP > 0) begin
                            state        <= S_GAP;
                            data_out_ack <= 1'b0;
                            gap_cnt      <= GAP_W'(ACK_GAP);
                        end
                    end else if (!enable) begin
                        state        <= S_IDLE;
                        data_out_ack <= 1'b0;
                        busy         <= 1'b0;
                    end
                end

                S_GAP: begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                    if (!enable) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (gap_cnt <= GAP_W'(1)) begin
                        state        <= S_ACK;
                        data_out_ack <= 1'b1;
                    end
                end

                S_DONE: begin
                    if (!enable) begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                    end
                end

                default: begin
                    state        <= S_IDLE;
                    data_out_ack <= 1'b0;
                    done         <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_checker.sv
// Scoreboard bench for fifo_stream_checker: u0 (4-bit data, no throttle) is
// driven word by word with hand-computed expected counters queued per word;
// u1 (4-bit data, ACK_GAP=2) checks the throttled ack pattern.
module tb_fifo_stream_checker;

    localparam int DW = 4;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          en1 = 1'b0;
    logic [CW-1:0] num_words = '0;
    logic [DW-1:0] data_out = '0;
    logic          data_out_valid = 1'b0;

    logic          ack0, err0, done0, busy0;
    logic [CW-1:0] wc0, ec0;
    logic          ack1, err1, done1, busy1;
    logic [CW-1:0] wc1, ec1;
`ifdef FIRST_ERR_CAPTURE_EN
    logic [CW-1:0] ei0, ei1;
    logic [DW-1:0] ee0, ea0, ee1, ea1;
`endif

    fifo_stream_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .ACK_GAP(0)) u0 (
        .clock(clock), .rst(rst), .enable(enable), .num_words(num_words),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_ack(ack0), .word_count(wc0), .err_count(ec0),
        .error(err0), .done(done0), .busy(busy0)
`ifdef FIRST_ERR_CAPTURE_EN
        , .err_index(ei0), .err_expected(ee0), .err_actual(ea0)
`endif
    );

    fifo_stream_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .ACK_GAP(2)) u1 (
        .clock(clock), .rst(rst), .enable(en1), .num_words(num_words),
        .data_out(data_out), .data_out_valid(data_out_valid),
        .data_out_ack(ack1), .word_count(wc1), .err_count(ec1),
        .error(err1), .done(done1), .busy(busy1)
`ifdef FIRST_ERR_CAPTURE_EN
        , .err_index(ei1), .err_expected(ee1), .err_actual(ea1)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [CW-1:0] wc;
        logic [CW-1:0] ec;
        logic          er;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   ack_hi = 0;
    logic pend = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: a transfer seen pending at one negedge is scored at the next.
    always @(negedge clock) begin
        exp_t e;
        if (pend) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_xfer: actual word_count=%0d required no transfer", wc0);
            end else begin
                e = exp_q.pop_front();
                check("xfer_word_count", 32'(wc0), 32'(e.wc));
                check("xfer_err_count", 32'(ec0), 32'(e.ec));
                check("xfer_error", 32'(err0), 32'(e.er));
            end
        end
        pend = !rst && ack0 && data_out_valid;
        if (ack0) ack_hi++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one word to u0 and hold it until accepted (bounded wait).
    task automatic send(input logic [DW-1:0] d, input int wc, input int ec, input logic er);
        logic x;
        int   t;
        exp_q.push_back('{wc: CW'(wc), ec: CW'(ec), er: er});
        data_out       = d;
        data_out_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clock);
            x = ack0;
            @(posedge clock);
            #1;
            t++;
        end while (!x && t < 20);
        if (!x) begin
            total++;
            bad++;
            $display("FAIL send_timeout: actual ack=0 required ack within 20 cycles (word %0h)", d);
        end
    endtask

    task automatic start(input int nw);
        num_words = CW'(nw);
        enable    = 1'b1;
    endtask

    task automatic finish_run();
        enable         = 1'b0;
        data_out_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] pat;

        // 1. Reset held with enable and valid high
        enable         = 1'b1;
        data_out_valid = 1'b1;
        data_out       = DW'(1);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ack", 32'(ack0), 0);
        check("rst_word_count", 32'(wc0), 0);
        check("rst_err_count", 32'(ec0), 0);
        check("rst_error", 32'(err0), 0);
        check("rst_done", 32'(done0), 0);
        check("rst_busy", 32'(busy0), 0);
        exp_q.push_back('{wc: CW'(1), ec: CW'(0), er: 1'b0});
        rst = 1'b0;
        tick();
        check("release_ack", 32'(ack0), 1);
        check("release_busy", 32'(busy0), 1);
        tick();
        enable         = 1'b0;
        data_out_valid = 1'b0;
        tick();
        check("stop_ack", 32'(ack0), 0);
        tick();

        // 2. Clean run of 5 words
        ack_hi = 0;
        start(5);
        for (int i = 1; i <= 5; i++) send(DW'(i), i, 0, 1'b0);
        check("clean_done", 32'(done0), 1);
        check("clean_ack_after", 32'(ack0), 0);
        check("clean_busy_after", 32'(busy0), 0);
        finish_run();
        check("clean_ack_cycles", 32'(ack_hi), 5);
        check("clean_idle_done", 32'(done0), 0);
        check("clean_hold_count", 32'(wc0), 5);

        // 3. Dropped word: 1,2,4,5
        start(4);
        send(DW'(1), 1, 0, 1'b0);
        send(DW'(2), 2, 0, 1'b0);
        send(DW'(4), 3, 1, 1'b1);
        send(DW'(5), 4, 1, 1'b1);
        check("drop_done", 32'(done0), 1);
`ifdef FIRST_ERR_CAPTURE_EN
        check("drop_err_index", 32'(ei0), 2);
        check("drop_err_expected", 32'(ee0), 3);
        check("drop_err_actual", 32'(ea0), 4);
`endif
        finish_run();

        // 4a. Wrap: 1..15 then 1 on 4-bit data
        start(16);
        for (int i = 1; i <= 15; i++) send(DW'(i), i, 0, 1'b0);
        send(DW'(1), 16, 0, 1'b0);
        check("wrap_done", 32'(done0), 1);
        finish_run();

        // 4b. Wrap with 0 after 15: one error, expected 1 actual 0
        start(16);
        for (int i = 1; i <= 15; i++) send(DW'(i), i, 0, 1'b0);
        send(DW'(0), 16, 1, 1'b1);
        check("wrap0_done", 32'(done0), 1);
`ifdef FIRST_ERR_CAPTURE_EN
        check("wrap0_err_index", 32'(ei0), 15);
        check("wrap0_err_expected", 32'(ee0), 1);
        check("wrap0_err_actual", 32'(ea0), 0);
`endif
        finish_run();

        // 5. Throttle on u1 (ACK_GAP=2), valid constant, 3 words
        pat            = 7'b1001001;
        num_words      = CW'(3);
        data_out       = DW'(1);
        data_out_valid = 1'b1;
        en1            = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k > 0 && pat[k-1]) data_out = data_out + DW'(1);
            check("throttle_ack", 32'(ack1), 32'(pat[k]));
        end
        check("throttle_not_done_yet", 32'(done1), 0);
        tick();
        check("throttle_done", 32'(done1), 1);
        check("throttle_ack_after", 32'(ack1), 0);
        check("throttle_word_count", 32'(wc1), 3);
        check("throttle_err_count", 32'(ec1), 0);
        check("throttle_busy", 32'(busy1), 0);
        en1            = 1'b0;
        data_out_valid = 1'b0;
        tick();
        tick();

        // 6. Backpressure then abort during a transfer
        start(0);
        send(DW'(1), 1, 0, 1'b0);
        data_out_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bp_ack", 32'(ack0), 1);
            check("bp_word_count", 32'(wc0), 1);
        end
        exp_q.push_back('{wc: CW'(2), ec: CW'(0), er: 1'b0});
        data_out       = DW'(2);
        data_out_valid = 1'b1;
        enable         = 1'b0;
        tick();
        check("abort_ack", 32'(ack0), 0);
        check("abort_busy", 32'(busy0), 0);
        data_out_valid = 1'b1;
        tick();
        check("abort_no_reack", 32'(ack0), 0);
        data_out_valid = 1'b0;
        tick();
        check("abort_word_count", 32'(wc0), 2);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
